// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide: shared shift-add / restoring-divide datapath; optional MULDIV_FAST_MUL_EN single-cycle multiplier.
// Latency: resp_valid after accept edge + 34 (iterative), + 1 (div special cases, fast multiply).
// Backpressure: one op in flight; req_ready only in IDLE; result held stable while resp_ready is low.

package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;
endpackage

module muldiv_unit
  import riscv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_e       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e            state, state_nxt;
  logic [4:0]        count;
  muldiv_op_e        op_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_q;
  logic              resp_valid_q;
  logic [XLEN-1:0]   result_q;

  // Request decode
  logic            is_div, a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            special, direct;
  logic [XLEN-1:0] special_res, direct_res;
  logic            accept;

  always_comb begin
    is_div   = op[2];
    a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    b_signed = (op == MULH) || (op == DIV) || (op == REM);
    sign_a   = a_signed & a[XLEN-1];
    sign_b   = b_signed & b[XLEN-1];
    mag_a    = sign_a ? (~a + 1'b1) : a;
    mag_b    = sign_b ? (~b + 1'b1) : b;
    // Remainder follows the dividend; product and quotient follow the sign xor.
    neg_in   = (op == REM) ? sign_a : (sign_a ^ sign_b);
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div && (b == '0)) begin
      special     = 1'b1;
      special_res = ((op == DIV) || (op == DIVU)) ? '1 : a;
    end else if (((op == DIV) || (op == REM)) && (a == 32'h8000_0000) && (b == '1)) begin
      special     = 1'b1;
      special_res = (op == DIV) ? 32'h8000_0000 : '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  always_comb begin
    fast_a     = {{XLEN{sign_a}}, a};
    fast_b     = {{XLEN{sign_b}}, b};
    fast_prod  = fast_a * fast_b;
    direct     = special || !is_div;
    direct_res = special ? special_res
               : (op == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    direct     = special;
    direct_res = special_res;
  end
`endif

  assign accept = req_valid && (state == IDLE) && !flush;

  // One iteration of each datapath; acc holds {product} or {remainder, quotient}
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic              div_ge;
  logic [XLEN-1:0]   rem_nxt;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_q} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mag_b_q});
    rem_nxt   = div_ge ? (div_shift[XLEN-1:0] - mag_b_q) : div_shift[XLEN-1:0];
    div_next  = {rem_nxt, acc[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q ? (~acc + 1'b1) : acc;
    quot_fix = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    rem_fix  = neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    case (op_q)
      MUL:       fix_res = prod_fix[XLEN-1:0];
      DIV, DIVU: fix_res = quot_fix;
      REM, REMU: fix_res = rem_fix;
      default:   fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = direct ? DONE : CALC;
      CALC:    if (count == 5'd31) state_nxt = FIXUP;
      FIXUP:   state_nxt = DONE;
      DONE:    if (resp_valid_q && resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result is loaded on entry to DONE and presented the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      resp_valid_q <= 1'b0;
    else
      resp_valid_q <= (state == DONE) && !flush && !(resp_valid_q && resp_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      op_q     <= MUL;
      mag_b_q  <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      count   <= '0;
      op_q    <= op;
      mag_b_q <= mag_b;
      acc     <= {{XLEN{1'b0}}, mag_a};
      neg_q   <= neg_in;
      if (direct) result_q <= direct_res;
    end else if (!flush) begin
      if (state == CALC) begin
        count <= count + 5'd1;
        acc   <= op_q[2] ? div_next : mul_next;
      end
      if (state == FIXUP) result_q <= fix_res;
    end
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = resp_valid_q;
  assign result     = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: results, latency, flush, backpressure and async reset.
module tb_muldiv_unit;
  import riscv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int SPC_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  muldiv_op_e  op = MUL;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int tests  = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue a request and return the number of edges after accept until resp_valid.
  task automatic issue(input muldiv_op_e o, input logic [31:0] aa, input logic [31:0] bb,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; op = o; a = aa; b = bb;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    check({tag, "_rdy_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run_op(input string tag, input muldiv_op_e o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(o, aa, bb, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check(tag, result, exp_res);
    handshake(tag);
  endtask

  initial begin
    int  lat;
    bit  saw_valid;

    #12;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    run_op("mul",     MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mulhu",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulh",    MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    run_op("mulhsu",  MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, MUL_LAT);
    run_op("div",     DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DIV_LAT);
    run_op("rem",     REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DIV_LAT);
    run_op("divu",    DIVU,   32'd100,      32'd7,        32'd14,        DIV_LAT);
    run_op("remu",    REMU,   32'd100,      32'd7,        32'd2,         DIV_LAT);
    run_op("div0",    DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, SPC_LAT);
    run_op("remu0",   REMU,   32'd5,        32'd0,        32'd5,         SPC_LAT);
    run_op("div_ovf", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    run_op("rem_ovf", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        SPC_LAT);

    // Flush mid-divide: no response, ready again right after the flush edge.
    @(negedge clk);
    req_valid = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_req_ready", {31'd0, req_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("flush_no_resp", {31'd0, saw_valid}, 32'd0);

    // Flush and request together in IDLE: request dropped.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = DIV; a = 32'd5; b = 32'd0;
    @(posedge clk); #1; req_valid = 1'b0; flush = 1'b0;
    check("flush_req_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("flush_req_no_resp", {31'd0, resp_valid}, 32'd0);

    // Backpressure: result and busy held while resp_ready is low.
    issue(DIVU, 32'd100, 32'd7, lat);
    check("bp_lat", lat, DIV_LAT);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", result, 32'd14);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
    end
    check("bp_not_ready", {31'd0, req_ready}, 32'd0);
    handshake("bp");
    check("bp_valid_clear", {31'd0, resp_valid}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    req_valid = 1'b1; op = DIV; a = 32'd77; b = 32'd5;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("arst_no_resp", {31'd0, saw_valid}, 32'd0);

    // Unit still works after reset.
    run_op("post_rst_divu", DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
